djb2_hash_seq: RTL and testbench
================================

// Module: djb2_hash_seq
// PURPOSE
//  Sequencer for the djb2 string-hash engine behind the djb2 AXI4-Lite slave.
//  Fetches a string from word memory, feeds it one byte per cycle through
//  h = h*33 + c (seed 5381), and reports the 32-bit result.
//  Start, base, length and abort come from the slave's register file.
//  hash, done and busy are read back through that register file.
// PARAMETERS
//  ADDR_W   32    byte-address width of the memory read port
//  LEN_W    16    width of string length / byte counters
//  SEED     5381  initial hash value (32'h0000_1505)
// PORTS
//  ACLK          in   1       clock, rising edge
//  ARESETN       in   1       asynchronous active-low reset
//  cfg_start     in   1       1-cycle pulse: begin hash; ignored while busy
//  cfg_abort     in   1       level/pulse: return to IDLE, no done
//  cfg_base      in   ADDR_W  byte address of string; bits[1:0] ignored (word aligned)
//  cfg_len       in   LEN_W   string length in bytes, sampled on accepted start
//  mem_req       out  1       read request, held until mem_gnt
//  mem_addr      out  ADDR_W  word-aligned read address, stable while mem_req
//  mem_gnt       in   1       request accepted this cycle
//  mem_rvalid    in   1       read data valid (one response per granted request)
//  mem_rdata     in   32      read data, byte 0 in [7:0] (little-endian)
//  busy          out  1       high from cycle after accepted start until DONE
//  done          out  1       1-cycle pulse: hash_out and hash_len valid
//  hash_out      out  32      final hash, held until next accepted start
//  hash_len      out  LEN_W   bytes actually hashed
// BEHAVIOUR
//  Reset (async): state=IDLE, mem_req=0, mem_addr=0, busy=0, done=0, hash_out=0, hash_len=0.
//  FSM: IDLE -> FETCH -> WAIT -> HASH -> (FETCH | DONE) -> IDLE.
//   IDLE : on cfg_start latch base/len, h=SEED, cnt=0. Then len==0 -> DONE, else -> FETCH.
//   FETCH: mem_req=1, mem_addr=ptr. On mem_gnt: drop req, ptr+=4 -> WAIT.
//   WAIT : on mem_rvalid capture mem_rdata into word buffer, lane=0 -> HASH.
//          mem_rdata is captured only in WAIT.
//   HASH : one byte per cycle, h = (h<<5)+h+byte mod 2^32, cnt++, lane++.
//          cnt==len -> DONE. lane==3 and cnt<len -> FETCH.
//   DONE : hash_out=h, hash_len=cnt, done=1 for exactly one cycle, busy=0 -> IDLE.
//  Single outstanding request; never two mem_req without an intervening rvalid.
//  Latency: len N = ceil(N/4) fetches + N hash cycles + 1 DONE cycle (zero-wait memory).
//  Final word: unused upper lanes are not hashed.
//  ptr wraps modulo 2^ADDR_W without error.
//  cfg_start while busy is ignored; cfg_start in same cycle as done is ignored.
//  cfg_abort:
//   - Any state -> IDLE next cycle; mem_req drops; no done; hash_out/hash_len unchanged.
//   - Abort during WAIT: the pending rvalid is swallowed (outstanding flag, cleared on rvalid).
//   - A new start is blocked until that rvalid has been swallowed.
//   - cfg_abort and cfg_start together: abort wins.
//  Reset mid-operation: immediate IDLE; a pending memory response after reset is ignored.
// CONFIGURATION
//  DJB2_NULL_TERM_EN defined:
//   - A 0x00 byte in HASH ends the string: not hashed, -> DONE.
//   - hash_len = bytes before the NUL; cfg_len acts as a maximum.
//  Undefined: 0x00 bytes are hashed like any other; only cfg_len terminates.
// TESTING
//  1 len=0, start -> no mem_req; done 2 cycles later; hash_out=32'h0000_1505, hash_len=0.
//  2 mem word0=32'h0063_6261 ("abc"), len=3 -> one fetch; hash_out=32'h0B88_5C8B, hash_len=3.
//  3 mem "ab" at 0x10, len=2; random mem_gnt/mem_rvalid stalls (0-5 cycles)
//    -> hash_out=32'h0059_7728; mem_req never drops before gnt; addr stable.
//  4 len=6 over 2 words ("abcdef..") -> exactly 2 fetches, addrs base, base+4.
//    Result equals the software djb2 model.
//  5 abort asserted while WAIT; late rvalid
//    -> no done; hash_out unchanged; next start(len=1,"a") gives 32'h0002_B606.
//  6 DJB2_NULL_TERM_EN, word=32'h0000_6261, len=8 -> hash_out=32'h0059_7728, hash_len=2.
//    Without the macro, same stimulus hashes 8 bytes over 2 fetches.
//  All: start pulsed while busy has no effect; ARESETN low mid-HASH clears all outputs.

Source files
------------

// File: rtl/djb2_hash_seq.sv
`default_nettype none
// djb2_hash_seq: fetches a byte string from word memory and hashes it one byte per cycle (h = h*33 + c).
// Optional build macro DJB2_NULL_TERM_EN: a 0x00 byte ends the string early.
module djb2_hash_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter logic [31:0] SEED   = 32'h0000_1505
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       hash_out,
  output logic [LEN_W-1:0]  hash_len
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HASH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [31:0]      h;
  logic [31:0]      word;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       lane;
  logic             outstanding;

  logic [7:0]        cur_byte;
  logic [31:0]       h_next;
  logic [LEN_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] base_aligned;
  logic              byte_ends;

  assign cur_byte     = word[{lane, 3'b000} +: 8];
  assign h_next       = (h << 5) + h + {24'd0, cur_byte};
  assign cnt_next     = cnt + LEN_ONE;
  assign base_aligned = cfg_base & ALIGN_MASK;

`ifdef DJB2_NULL_TERM_EN
  assign byte_ends = (cur_byte == 8'h00);
`else
  assign byte_ends = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hash_out    <= '0;
      hash_len    <= '0;
      h           <= SEED;
      word        <= '0;
      len         <= '0;
      cnt         <= '0;
      lane        <= '0;
      outstanding <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mem_rvalid) begin
        outstanding <= 1'b0;
      end
      if (cfg_abort) begin
        state   <= S_IDLE;
        mem_req <= 1'b0;
        busy    <= 1'b0;
        // A granted read whose data has not yet returned must be swallowed later.
        if ((state == S_WAIT && !mem_rvalid) || (state == S_FETCH && mem_gnt)) begin
          outstanding <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start && !done && !outstanding) begin
              len      <= cfg_len;
              h        <= SEED;
              cnt      <= '0;
              lane     <= '0;
              busy     <= 1'b1;
              mem_addr <= base_aligned;
              if (cfg_len == '0) begin
                state <= S_DONE;
              end else begin
                state   <= S_FETCH;
                mem_req <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_rvalid) begin
              word  <= mem_rdata;
              lane  <= '0;
              state <= S_HASH;
            end
          end
          S_HASH: begin
            if (byte_ends) begin
              state <= S_DONE;
            end else begin
              h    <= h_next;
              cnt  <= cnt_next;
              lane <= lane + 2'd1;
              if (cnt_next == len) begin
                state <= S_DONE;
              end else if (lane == 2'd3) begin
                state    <= S_FETCH;
                mem_req  <= 1'b1;
                mem_addr <= mem_addr + WORD_STEP;
              end
            end
          end
          S_DONE: begin
            hash_out <= h;
            hash_len <= cnt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_djb2_hash_seq.sv
`default_nettype none
// Bench for djb2_hash_seq: vector table against a stalling word-memory model, plus abort/reset/start corner sequences.
module tb_djb2_hash_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_len = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] hash_out;
  logic [15:0] hash_len;

  djb2_hash_seq #(.ADDR_W(32), .LEN_W(16), .SEED(32'h0000_1505)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .hash_out(hash_out), .hash_len(hash_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model with randomisable grant and response delays
  logic [31:0] mem [0:63];
  int unsigned gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
  int          fetch_cnt = 0;
  logic [31:0] addr_log [0:7];
  int          proto_err = 0;

  initial begin
    bit          rv_pend;
    int unsigned rv_cnt;
    int unsigned g_cnt;
    bit          g_armed;
    logic [31:0] pend_addr;
    logic        prev_req, prev_gnt;
    logic [31:0] prev_addr;
    rv_pend = 0; rv_cnt = 0; g_cnt = 0; g_armed = 0; pend_addr = '0;
    prev_req = 0; prev_gnt = 0; prev_addr = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_req && !prev_gnt && busy && !(mem_req && mem_addr == prev_addr)) proto_err++;
        if (mem_req && rv_pend) proto_err++;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst_n) begin
        rv_pend = 0;
        g_armed = 0;
      end else if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pend_addr[7:2]];
          rv_pend    = 0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req) begin
        if (!g_armed) begin
          g_cnt   = $urandom_range(gnt_hi, gnt_lo);
          g_armed = 1;
        end
        if (g_cnt == 0) begin
          mem_gnt   = 1'b1;
          g_armed   = 0;
          pend_addr = mem_addr;
          rv_pend   = 1;
          rv_cnt    = $urandom_range(rv_hi, rv_lo);
          if (fetch_cnt < 8) addr_log[fetch_cnt] = mem_addr;
          fetch_cnt++;
        end else begin
          g_cnt--;
        end
      end else begin
        g_armed = 0;
      end
      prev_gnt = mem_gnt;
    end
  end

  // Software djb2 over memory bytes starting at the word-aligned base
  function automatic logic [31:0] model_hash(input logic [31:0] base, input int len, output int nlen);
    logic [31:0] h;
    logic [31:0] a;
    logic [7:0]  b;
    h = 32'd5381;
    nlen = 0;
    for (int i = 0; i < len; i++) begin
      a = {base[31:2], 2'b00} + 32'(i);
      b = mem[a[7:2]][{a[1:0], 3'b000} +: 8];
`ifdef DJB2_NULL_TERM_EN
      if (b == 8'h00) break;
`endif
      h = h * 32'd33 + {24'd0, b};
      nlen++;
    end
    return h;
  endfunction

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [31:0] exp_hash;
    logic [15:0] exp_len;
    int          exp_fetch;
    int          exp_lat;
    bit          stall;
  } vec_t;

  vec_t vecs [0:6];

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bit got;
    logic [31:0] ab;
    ab = v.base & 32'hFFFF_FFFC;
    fetch_cnt = 0;
    gnt_lo = 0; rv_lo = 0;
    gnt_hi = v.stall ? 5 : 0;
    rv_hi  = v.stall ? 5 : 0;
    @(negedge clk);
    cfg_base = v.base; cfg_len = v.len; cfg_start = 1'b1;
    @(negedge clk);
    // second start while busy, with different config, must be ignored
    cfg_len = v.len + 16'd1; cfg_base = v.base + 32'd4; cfg_start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      cfg_start = 1'b0;
      if (done) got = 1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_hash"}, hash_out, v.exp_hash);
      chk({tag, "_len"}, 32'(hash_len), 32'(v.exp_len));
      chk({tag, "_fetches"}, 32'(fetch_cnt), 32'(v.exp_fetch));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (fetch_cnt > 0) chk({tag, "_addr0"}, addr_log[0], ab);
      if (fetch_cnt > 1) chk({tag, "_addr1"}, addr_log[1], ab + 32'd4);
      if (!v.stall) chk({tag, "_latency"}, 32'(n), 32'(v.exp_lat));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_no_restart"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int nl;
    int dcount;
    bit got;
    vec_t va;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 32'h0063_6261;  // "abc"
    mem[4]  = 32'h0000_6261;  // "ab" at 0x10
    mem[8]  = 32'h6463_6261;  // "abcd" at 0x20
    mem[9]  = 32'h0000_6665;  // "ef"
    mem[12] = 32'h0000_6261;  // "ab\0\0" at 0x30
    mem[13] = 32'h4433_2211;
    mem[16] = 32'h0000_0061;  // "a" at 0x40
    mem[63] = 32'h6463_6261;  // "abcd" at 0xFC

    vecs[0] = '{32'h0000_0000, 16'd0, 32'h0000_1505, 16'd0, 0, 1, 1'b0};
    vecs[1] = '{32'h0000_0000, 16'd3, 32'h0B88_5C8B, 16'd3, 1, 6, 1'b0};
    vecs[2] = '{32'h0000_0010, 16'd2, 32'h0059_7728, 16'd2, 1, 0, 1'b1};
    vecs[3] = '{32'h0000_0020, 16'd6, 32'hF148_CB7A, 16'd6, 2, 11, 1'b0};
`ifdef DJB2_NULL_TERM_EN
    vecs[4] = '{32'h0000_0030, 16'd8, 32'h0059_7728, 16'd2, 1, 6, 1'b0};
`else
    vecs[4] = '{32'h0000_0030, 16'd8, 32'h0, 16'd8, 2, 13, 1'b0};
    vecs[4].exp_hash = model_hash(32'h0000_0030, 8, nl);
`endif
    vecs[5] = '{32'h0000_0042, 16'd1, 32'h0002_B606, 16'd1, 1, 4, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 16'd5, 32'h0F11_B890, 16'd5, 2, 10, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hash_out", hash_out, 32'd0);
    chk("rst_hash_len", 32'(hash_len), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort while waiting for read data; late response must be swallowed
    gnt_lo = 0; gnt_hi = 0; rv_lo = 5; rv_hi = 5;
    @(negedge clk);
    cfg_base = 32'h0; cfg_len = 16'd4; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      if (mem_gnt) got = 1;
    end
    chk("abort_gnt_seen", 32'(got), 32'd1);
    @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    cfg_base = 32'h40; cfg_len = 16'd1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("abort_start_blocked", 32'(busy), 32'd0);
    chk("abort_req_low", 32'(mem_req), 32'd0);
    chk("abort_hash_kept", hash_out, vecs[6].exp_hash);
    chk("abort_len_kept", 32'(hash_len), 32'(vecs[6].exp_len));
    dcount = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      if (done) dcount++;
      if (mem_rvalid) got = 1;
    end
    chk("abort_late_rvalid", 32'(got), 32'd1);
    chk("abort_no_done", 32'(dcount), 32'd0);
    va = '{32'h0000_0040, 16'd1, 32'h0002_B606, 16'd1, 1, 4, 1'b0};
    run_vec(va, "after_abort");

    // Reset mid-HASH clears all outputs
    gnt_hi = 0; rv_hi = 0; rv_lo = 0;
    @(negedge clk);
    cfg_base = 32'h20; cfg_len = 16'd8; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hash_out", hash_out, 32'd0);
    chk("midrst_hash_len", 32'(hash_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1], "after_rst");

    // Start coincident with done is ignored
    @(negedge clk);
    cfg_base = 32'h0; cfg_len = 16'd0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    chk("dstart_done", 32'(done), 32'd1);
    cfg_len = 16'd3; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("dstart_ignored", 32'(busy), 32'd0);
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("dstart_no_done", 32'(dcount), 32'd0);

    chk("req_protocol", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
